// File: rtl/sigmoid_pla_pkg.sv
// Shared constants for the 4-slice Q8.8 sigmoid and its piecewise-linear inverse (logit).
// Breakpoints are on the probability axis; reciprocal slopes are Q8.8 x-per-y factors.
package sigmoid_pla_pkg;

  localparam int FIXED_POINT = 8;

  localparam logic [15:0] BP_LO  = 16'd12;
  localparam logic [15:0] BP_MID = 16'd128;
  localparam logic [15:0] BP_HI  = 16'd244;
  localparam logic [15:0] BP_SAT = 16'd256;

  localparam logic signed [16:0] RECIP_CENTER = 17'sd1697;
  localparam logic signed [16:0] RECIP_TAIL   = 17'sd17090;

  localparam logic signed [16:0] BASE_LO  = -17'sd768;
  localparam logic signed [16:0] BASE_MID = 17'sd0;
  localparam logic signed [16:0] BASE_HI  = 17'sd768;

  localparam logic signed [16:0] SAT_LIMIT  = 17'sd1536;
  localparam logic signed [32:0] ROUND_BIAS = 33'sd128;

  // Signed distance of y from a breakpoint; y is unsigned so it is zero-extended first.
  function automatic logic signed [16:0] diff_from(input logic [15:0] y, input logic [15:0] bp);
    return $signed({1'b0, y}) - $signed({1'b0, bp});
  endfunction

  function automatic logic signed [15:0] clamp_q88(input logic signed [32:0] v);
    if (v > 33'(SAT_LIMIT)) return 16'(SAT_LIMIT);
    if (v < 33'(-SAT_LIMIT)) return 16'(-SAT_LIMIT);
    return v[15:0];
  endfunction

endpackage

// File: rtl/logit_segment_decode.sv
// Combinational segment select for the logit inverse: picks breakpoint offset,
// reciprocal slope and base for y, or flags saturation at either end.
module logit_segment_decode
  import sigmoid_pla_pkg::*;
(
  input  logic [15:0]        y,
  output logic signed [16:0] diff,
  output logic signed [16:0] recip,
  output logic signed [16:0] base,
  output logic               sat_lo,
  output logic               sat_hi
);

  always_comb begin
    diff   = '0;
    recip  = '0;
    base   = '0;
    sat_lo = 1'b0;
    sat_hi = 1'b0;
    if (y == 16'd0) begin
      sat_lo = 1'b1;
      base   = -SAT_LIMIT;
    end else if (y < BP_LO) begin
      diff  = diff_from(y, BP_LO);
      recip = RECIP_TAIL;
      base  = BASE_LO;
    end else if (y < BP_HI) begin
      diff  = diff_from(y, BP_MID);
      recip = RECIP_CENTER;
      base  = BASE_MID;
    end else if (y < BP_SAT) begin
      diff  = diff_from(y, BP_HI);
      recip = RECIP_TAIL;
      base  = BASE_HI;
    end else begin
      // Covers everything >= 1.0, including the top half of the unsigned range.
      sat_hi = 1'b1;
      base   = SAT_LIMIT;
    end
  end

endmodule

// File: rtl/logit_pla_pipelined.sv
// Three-stage piecewise-linear logit (inverse of the Q8.8 sigmoid) with valid/ready flow.
// Build option LOGIT_ROUND_EN: round half up before the >>>8 instead of flooring.
module logit_pla_pipelined
  import sigmoid_pla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        y_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic signed [15:0] x_out,
  output logic               valid_out,
  input  logic               ready_in
);

  // Handshake: a beat transfers when valid && ready on the same posedge. The whole
  // pipe moves together on advance, so an accepted input is valid_in && advance.
  logic advance;
  assign advance   = !valid_out || ready_in;
  assign ready_out = advance;

  logic signed [16:0] d_diff, d_recip, d_base;
  logic               d_sat_lo, d_sat_hi;

  logit_segment_decode u_decode (
    .y      (y_in),
    .diff   (d_diff),
    .recip  (d_recip),
    .base   (d_base),
    .sat_lo (d_sat_lo),
    .sat_hi (d_sat_hi)
  );

  logic               s1_valid, s1_sat_lo, s1_sat_hi;
  logic signed [16:0] s1_diff, s1_recip, s1_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_recip  <= '0;
      s1_base   <= '0;
      s1_sat_lo <= 1'b0;
      s1_sat_hi <= 1'b0;
    end else if (advance) begin
      s1_valid  <= valid_in;
      s1_diff   <= d_diff;
      s1_recip  <= d_recip;
      s1_base   <= d_base;
      s1_sat_lo <= d_sat_lo;
      s1_sat_hi <= d_sat_hi;
    end
  end

  logic signed [32:0] mul_a, mul_b, product;
  assign mul_a   = 33'(s1_diff);
  assign mul_b   = 33'(s1_recip);
  assign product = mul_a * mul_b;

  logic               s2_valid, s2_sat_lo, s2_sat_hi;
  logic signed [32:0] s2_prod;
  logic signed [16:0] s2_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_base   <= '0;
      s2_sat_lo <= 1'b0;
      s2_sat_hi <= 1'b0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_prod   <= product;
      s2_base   <= s1_base;
      s2_sat_lo <= s1_sat_lo;
      s2_sat_hi <= s1_sat_hi;
    end
  end

  logic signed [32:0] biased, scaled, sum;
  logic signed [15:0] x_next;

  always_comb begin
`ifdef LOGIT_ROUND_EN
    biased = s2_prod + ROUND_BIAS;
`else
    biased = s2_prod;
`endif
    scaled = biased >>> FIXED_POINT;
    sum    = scaled + 33'(s2_base);
    if (s2_sat_lo)      x_next = 16'(-SAT_LIMIT);
    else if (s2_sat_hi) x_next = 16'(SAT_LIMIT);
    else                x_next = clamp_q88(sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      x_out     <= '0;
    end else if (advance) begin
      valid_out <= s2_valid;
      x_out     <= x_next;
    end
  end

endmodule
